// File: rtl/mem_stage_memwb.sv
// MEM stage of the 5-stage MIPS pipeline: word-addressed data memory plus the MEM/WB register.
// A load reads the array combinationally, and the result is captured at the same edge that commits a store.
`timescale 1ns/1ps
module mem_stage_memwb #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ex_wb_control,
  input  logic [1:0]  ex_m_control,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_write_reg,
  input  logic        stall,
  input  logic        flush,
  output logic [1:0]  wb_control,
  output logic [31:0] mem_read_data,
  output logic [31:0] alu_result,
  output logic [4:0]  wb_write_reg,
  output logic        mem_err
);

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] idx_s;
  logic              mem_read_s;
  logic              mem_write_s;
  logic              bad_s;
  logic              store_en_s;
  logic [31:0]       load_data_s;

  logic [1:0]  wb_control_q, wb_control_d;
  logic [31:0] mem_read_data_q, mem_read_data_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [4:0]  wb_write_reg_q, wb_write_reg_d;
  logic        mem_err_q, mem_err_d;

  assign mem_read_s  = ex_m_control[1];
  assign mem_write_s = ex_m_control[0];
  assign idx_s       = ex_alu_result[ADDR_W+1:2];
  // Misaligned byte offset or any address bit above the array span makes the access illegal.
  assign bad_s       = (ex_alu_result[1:0] != 2'b00) ||
                       (ex_alu_result[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});
  assign store_en_s  = mem_write_s & ~bad_s & ~stall & ~flush & ~rst;

  // Load path: read data for a legal load, and zero for a non-load or an illegal load.
  always_comb begin
    load_data_s = 32'h0000_0000;
    if (mem_read_s && !bad_s) begin
      load_data_s = mem_q[idx_s];
    end else begin
      load_data_s = 32'h0000_0000;
    end
  end

  // Next-state logic for MEM/WB with the priority order flush, then stall, then normal advance.
  always_comb begin
    wb_control_d    = wb_control_q;
    mem_read_data_d = mem_read_data_q;
    alu_result_d    = alu_result_q;
    wb_write_reg_d  = wb_write_reg_q;
    mem_err_d       = mem_err_q;
    if (flush) begin
      wb_control_d    = 2'b00;
      mem_read_data_d = 32'h0000_0000;
      alu_result_d    = 32'h0000_0000;
      wb_write_reg_d  = 5'd0;
      mem_err_d       = 1'b0;
    end else if (stall) begin
      wb_control_d    = wb_control_q;
      mem_read_data_d = mem_read_data_q;
      alu_result_d    = alu_result_q;
      wb_write_reg_d  = wb_write_reg_q;
      mem_err_d       = mem_err_q;
    end else begin
      // A faulting load must not write the register file, so RegWrite is dropped.
      wb_control_d    = {ex_wb_control[1] & ~(mem_read_s & bad_s), ex_wb_control[0]};
      mem_read_data_d = load_data_s;
      alu_result_d    = ex_alu_result;
      wb_write_reg_d  = ex_write_reg;
      mem_err_d       = bad_s & (mem_read_s | mem_write_s);
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_control_q    <= 2'b00;
      mem_read_data_q <= 32'h0000_0000;
      alu_result_q    <= 32'h0000_0000;
      wb_write_reg_q  <= 5'd0;
      mem_err_q       <= 1'b0;
    end else begin
      wb_control_q    <= wb_control_d;
      mem_read_data_q <= mem_read_data_d;
      alu_result_q    <= alu_result_d;
      wb_write_reg_q  <= wb_write_reg_d;
      mem_err_q       <= mem_err_d;
    end
  end

  // Data memory write port. The contents are intentionally left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (store_en_s) begin
      mem_q[idx_s] <= ex_store_data;
    end
  end

  assign wb_control    = wb_control_q;
  assign mem_read_data = mem_read_data_q;
  assign alu_result    = alu_result_q;
  assign wb_write_reg  = wb_write_reg_q;
  assign mem_err       = mem_err_q;

endmodule

// File: tb/tb_mem_stage_memwb.sv
// Bench for mem_stage_memwb. It applies table-driven vectors, then hand-written sequences for stall and for asynchronous reset.
// Expected MEM/WB contents go through a scoreboard queue.
`timescale 1ns/1ps
module tb_mem_stage_memwb;

  typedef struct {
    logic [1:0]  wbc;
    logic [1:0]  mc;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  wr;
    logic        stall;
    logic        flush;
  } in_t;

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        err;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ex_wb_control;
  logic [1:0]  ex_m_control;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_write_reg;
  logic        stall;
  logic        flush;
  logic [1:0]  wb_control;
  logic [31:0] mem_read_data;
  logic [31:0] alu_result;
  logic [4:0]  wb_write_reg;
  logic        mem_err;

  int   n_vec = 0;
  int   n_err = 0;
  out_t sb_q[$];
  vec_t tbl[$];
  out_t zero_o;

  mem_stage_memwb dut (
    .clk(clk), .rst(rst),
    .ex_wb_control(ex_wb_control), .ex_m_control(ex_m_control),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .stall(stall), .flush(flush),
    .wb_control(wb_control), .mem_read_data(mem_read_data),
    .alu_result(alu_result), .wb_write_reg(wb_write_reg), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] wbc, input logic [1:0] mc,
                              input logic [31:0] alu, input logic [31:0] sd,
                              input logic [4:0] wr, input logic st, input logic fl,
                              input logic [1:0] ewb, input logic [31:0] erd,
                              input logic [31:0] ealu, input logic [4:0] ewr,
                              input logic eerr);
    vec_t v;
    v.in.wbc = wbc;  v.in.mc = mc;  v.in.alu = alu;  v.in.sd = sd;
    v.in.wr = wr;    v.in.stall = st;  v.in.flush = fl;
    v.exp.wb = ewb;  v.exp.rd = erd;  v.exp.alu = ealu;
    v.exp.wr = ewr;  v.exp.err = eerr;
    return v;
  endfunction

  task automatic check(input string name, input out_t e);
    n_vec++;
    if (wb_control !== e.wb || mem_read_data !== e.rd || alu_result !== e.alu ||
        wb_write_reg !== e.wr || mem_err !== e.err) begin
      n_err++;
      $display("FAIL %s: got wb=%b rd=%h alu=%h wr=%0d err=%b, want wb=%b rd=%h alu=%h wr=%0d err=%b",
               name, wb_control, mem_read_data, alu_result, wb_write_reg, mem_err,
               e.wb, e.rd, e.alu, e.wr, e.err);
    end
  endtask

  task automatic drive(input in_t i);
    ex_wb_control = i.wbc;  ex_m_control = i.mc;  ex_alu_result = i.alu;
    ex_store_data = i.sd;   ex_write_reg = i.wr;  stall = i.stall;  flush = i.flush;
  endtask

  task automatic apply(input string name, input vec_t v);
    out_t e;
    @(negedge clk);
    drive(v.in);
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check(name, e);
    end
  endtask

  initial begin
    zero_o = '{wb: 2'b00, rd: 32'h0, alu: 32'h0, wr: 5'd0, err: 1'b0};
    rst = 1'b1;
    drive(mk(2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0,
             2'b00, 32'h0, 32'h0, 5'd0, 1'b0).in);

    //     wbc    mc     alu            sd             wr     st    fl    | wb     rd             alu            wr     err
    tbl.push_back(mk(2'b00, 2'b01, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 2'b00, 32'h0,          32'h0000_0010, 5'd0,  1'b0));
    tbl.push_back(mk(2'b11, 2'b10, 32'h0000_0010, 32'h0,         5'd5,  1'b0, 1'b0, 2'b11, 32'hDEAD_BEEF, 32'h0000_0010, 5'd5,  1'b0));
    tbl.push_back(mk(2'b10, 2'b00, 32'h1234_5678, 32'h0,         5'd7,  1'b0, 1'b0, 2'b10, 32'h0,          32'h1234_5678, 5'd7,  1'b0));
    tbl.push_back(mk(2'b00, 2'b01, 32'h0000_0000, 32'hA5A5_0000, 5'd0,  1'b0, 1'b0, 2'b00, 32'h0,          32'h0000_0000, 5'd0,  1'b0));
    tbl.push_back(mk(2'b11, 2'b10, 32'h0000_0013, 32'h0,         5'd9,  1'b0, 1'b0, 2'b01, 32'h0,          32'h0000_0013, 5'd9,  1'b1));
    tbl.push_back(mk(2'b00, 2'b01, 32'h0000_0400, 32'hBAD0_BAD0, 5'd0,  1'b0, 1'b0, 2'b00, 32'h0,          32'h0000_0400, 5'd0,  1'b1));
    tbl.push_back(mk(2'b11, 2'b10, 32'h0000_0010, 32'h0,         5'd9,  1'b1, 1'b0, 2'b00, 32'h0,          32'h0000_0400, 5'd0,  1'b1));
    tbl.push_back(mk(2'b11, 2'b10, 32'h0000_0000, 32'h0,         5'd3,  1'b0, 1'b0, 2'b11, 32'hA5A5_0000, 32'h0000_0000, 5'd3,  1'b0));
    tbl.push_back(mk(2'b10, 2'b00, 32'hFFFF_FFF3, 32'h0,         5'd31, 1'b0, 1'b0, 2'b10, 32'h0,          32'hFFFF_FFF3, 5'd31, 1'b0));
    tbl.push_back(mk(2'b11, 2'b11, 32'h0000_0010, 32'h55AA_55AA, 5'd4,  1'b0, 1'b0, 2'b11, 32'hDEAD_BEEF, 32'h0000_0010, 5'd4,  1'b0));
    tbl.push_back(mk(2'b11, 2'b10, 32'h0000_0010, 32'h0,         5'd4,  1'b0, 1'b0, 2'b11, 32'h55AA_55AA, 32'h0000_0010, 5'd4,  1'b0));
    tbl.push_back(mk(2'b11, 2'b10, 32'h8000_0000, 32'h0,         5'd2,  1'b0, 1'b0, 2'b01, 32'h0,          32'h8000_0000, 5'd2,  1'b1));
    tbl.push_back(mk(2'b00, 2'b01, 32'h0000_0030, 32'h3030_3030, 5'd0,  1'b0, 1'b0, 2'b00, 32'h0,          32'h0000_0030, 5'd0,  1'b0));
    tbl.push_back(mk(2'b11, 2'b01, 32'h0000_0030, 32'h1111_1111, 5'd6,  1'b1, 1'b1, 2'b00, 32'h0,          32'h0,          5'd0,  1'b0));
    tbl.push_back(mk(2'b11, 2'b10, 32'h0000_0030, 32'h0,         5'd6,  1'b0, 1'b0, 2'b11, 32'h3030_3030, 32'h0000_0030, 5'd6,  1'b0));
    tbl.push_back(mk(2'b01, 2'b00, 32'hFFFF_FFFC, 32'h0,         5'd12, 1'b0, 1'b0, 2'b01, 32'h0,          32'hFFFF_FFFC, 5'd12, 1'b0));
    tbl.push_back(mk(2'b10, 2'b00, 32'h0000_AAAA, 32'h0,         5'd13, 1'b0, 1'b1, 2'b00, 32'h0,          32'h0,          5'd0,  1'b0));
    tbl.push_back(mk(2'b10, 2'b10, 32'h0000_0012, 32'h0,         5'd14, 1'b0, 1'b0, 2'b00, 32'h0,          32'h0000_0012, 5'd14, 1'b1));

    #2;
    check("reset_initial", zero_o);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // A store held by a three-cycle stall must leave MEM/WB frozen and commit once on release.
    apply("stall_pre",  mk(2'b10, 2'b00, 32'h0BAD_F00D, 32'h0, 5'd8, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0BAD_F00D, 5'd8, 1'b0));
    for (int c = 0; c < 3; c++) begin
      apply($sformatf("stall_hold%0d", c),
            mk(2'b00, 2'b01, 32'h0000_0020, 32'hCAFE_BABE, 5'd0, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0BAD_F00D, 5'd8, 1'b0));
    end
    apply("stall_rel",  mk(2'b00, 2'b01, 32'h0000_0020, 32'hCAFE_BABE, 5'd0,  1'b0, 1'b0, 2'b00, 32'h0,          32'h0000_0020, 5'd0,  1'b0));
    apply("stall_lw",   mk(2'b11, 2'b10, 32'h0000_0020, 32'h0,         5'd10, 1'b0, 1'b0, 2'b11, 32'hCAFE_BABE, 32'h0000_0020, 5'd10, 1'b0));
    // A stalled store whose slot is then taken by a different instruction must never reach memory.
    apply("sq_pre",     mk(2'b00, 2'b01, 32'h0000_0028, 32'h2828_2828, 5'd0,  1'b0, 1'b0, 2'b00, 32'h0,          32'h0000_0028, 5'd0,  1'b0));
    apply("sq_st0",     mk(2'b00, 2'b01, 32'h0000_0028, 32'h9999_9999, 5'd0,  1'b1, 1'b0, 2'b00, 32'h0,          32'h0000_0028, 5'd0,  1'b0));
    apply("sq_st1",     mk(2'b00, 2'b01, 32'h0000_0028, 32'h9999_9999, 5'd0,  1'b1, 1'b0, 2'b00, 32'h0,          32'h0000_0028, 5'd0,  1'b0));
    apply("sq_rtype",   mk(2'b10, 2'b00, 32'h0000_600D, 32'h0,         5'd1,  1'b0, 1'b0, 2'b10, 32'h0,          32'h0000_600D, 5'd1,  1'b0));
    apply("sq_lw",      mk(2'b11, 2'b10, 32'h0000_0028, 32'h0,         5'd2,  1'b0, 1'b0, 2'b11, 32'h2828_2828, 32'h0000_0028, 5'd2,  1'b0));

    // Asserting reset mid-cycle during a stalled store must clear the outputs at once and block the store.
    @(negedge clk);
    drive(mk(2'b11, 2'b01, 32'h0000_0030, 32'h7777_7777, 5'd3, 1'b1, 1'b0,
             2'b00, 32'h0, 32'h0, 5'd0, 1'b0).in);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", zero_o);
    @(posedge clk);
    #1;
    check("rst_hold_stall", zero_o);
    @(negedge clk);
    stall = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_store", zero_o);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0,
             2'b00, 32'h0, 32'h0, 5'd0, 1'b0).in);
    apply("rst_lw",     mk(2'b11, 2'b10, 32'h0000_0030, 32'h0,         5'd6,  1'b0, 1'b0, 2'b11, 32'h3030_3030, 32'h0000_0030, 5'd6,  1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
